// File: rtl/periph_dispatch.sv
// Host-to-peripheral router: decodes the 3-bit address in each USB packet header and forwards
// the packet to that peripheral's TX FIFO through a 2-entry buffer, counting dropped packets.
module periph_dispatch #(
    parameter int unsigned NUM_PERIPHERALS = 8,
    parameter int unsigned PACKET_WIDTH    = 32,
    parameter int unsigned ADDR_MSB        = 31,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PACKET_WIDTH-1:0]    in_data,
    input  logic [3:0]                 in_be,
    output logic                       in_ready,
    input  logic [NUM_PERIPHERALS-1:0] periph_en,
    input  logic [NUM_PERIPHERALS-1:0] tx_full,
    output logic [PACKET_WIDTH-1:0]    tx_data,
    output logic [NUM_PERIPHERALS-1:0] tx_valid,
    output logic [CNT_WIDTH-1:0]       drop_addr_cnt,
    output logic [CNT_WIDTH-1:0]       drop_partial_cnt,
    output logic                       blocked
);

    typedef enum logic [1:0] {StEmpty, StReady, StWait} state_e;

    logic [PACKET_WIDTH-1:0]    buf_q [2];
    logic                       head_q, head_d;
    logic                       tail_q, tail_d;
    logic [1:0]                 count_q, count_d;
    logic [PACKET_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic [NUM_PERIPHERALS-1:0] tx_valid_q, tx_valid_d;
    logic [CNT_WIDTH-1:0]       drop_addr_q, drop_partial_q;
    logic                       blocked_q, blocked_d;

    state_e     state;
    logic [7:0] en_ext, full_ext;
    logic [2:0] in_addr, head_addr;
    logic       offer, accept, partial, addr_bad;
    logic       push, pop, partial_inc, addr_inc;

    // Widen per-port masks to the full 3-bit address space; missing ports read as 0.
    assign en_ext    = 8'(periph_en);
    assign full_ext  = 8'(tx_full);
    assign in_addr   = in_data[ADDR_MSB -: 3];
    assign head_addr = buf_q[head_q][ADDR_MSB -: 3];

    // Ready depends only on the registered count, never on tx_full.
    assign in_ready = !rst && (count_q != 2'd2);

    assign offer    = (in_be != 4'h0);
    assign accept   = offer && in_ready;
    assign partial  = (in_be != 4'hF);
    assign addr_bad = (32'(in_addr) >= NUM_PERIPHERALS) || !en_ext[in_addr];

    assign push        = accept && !partial && !addr_bad;
    assign partial_inc = accept && partial && (drop_partial_q != '1);
    assign addr_inc    = accept && !partial && addr_bad && (drop_addr_q != '1);

    // Dispatch state is a pure decode of buffer occupancy and the head target's full flag.
    always_comb begin
        if (count_q == 2'd0) begin
            state = StEmpty;
        end else if (full_ext[head_addr]) begin
            state = StWait;
        end else begin
            state = StReady;
        end
    end

    assign pop = (state == StReady);

    // Next-state: buffer pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Outputs: registered write strobe, shared data and blocked flag.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = '0;
        blocked_d  = (state == StWait);
        if (pop) begin
            tx_data_d = buf_q[head_q];
        end
        for (int unsigned i = 0; i < NUM_PERIPHERALS; i++) begin
            if (pop && (head_addr == 3'(i))) begin
                tx_valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            tx_data_q  <= '0;
            tx_valid_q <= '0;
            blocked_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            blocked_q  <= blocked_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (push) begin
            buf_q[tail_q] <= in_data;
        end
    end

    // Counters only update on a drop so they saturate and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_partial_q <= '0;
            drop_addr_q    <= '0;
        end else begin
            if (partial_inc) begin
                drop_partial_q <= drop_partial_q + CNT_WIDTH'(1);
            end
            if (addr_inc) begin
                drop_addr_q <= drop_addr_q + CNT_WIDTH'(1);
            end
        end
    end

    assign tx_data          = tx_data_q;
    assign tx_valid         = tx_valid_q;
    assign drop_addr_cnt    = drop_addr_q;
    assign drop_partial_cnt = drop_partial_q;
    assign blocked          = blocked_q;

endmodule

// File: tb/tb_periph_dispatch.sv
// Self-checking bench for periph_dispatch: vector table plus hand sequences, with a scoreboard
// queue of expected packets compared whenever tx_valid fires.
module tb_periph_dispatch;

    typedef enum int {KFwd, KPart, KAddr, KNone} kind_e;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  en;
        kind_e       kind;
    } vec_t;

    typedef struct {
        logic [7:0]  onehot;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_be = '0;
    logic        in_ready;
    logic [7:0]  periph_en = 8'hFF;
    logic [7:0]  tx_full = 8'h00;
    logic [31:0] tx_data;
    logic [7:0]  tx_valid;
    logic [15:0] drop_addr_cnt;
    logic [15:0] drop_partial_cnt;
    logic        blocked;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    logic [15:0] exp_part = '0;
    logic [15:0] exp_addr = '0;

    periph_dispatch dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_be            (in_be),
        .in_ready         (in_ready),
        .periph_en        (periph_en),
        .tx_full          (tx_full),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .drop_addr_cnt    (drop_addr_cnt),
        .drop_partial_cnt (drop_partial_cnt),
        .blocked          (blocked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] addr, input int payload);
        logic [31:0] w;
        w = {addr, 29'(payload)};
        return w;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Drive one word for one cycle; record the expected effect if it is accepted.
    task automatic send(input logic [3:0] be, input logic [31:0] data, input kind_e kind);
        exp_t e;
        in_be   = be;
        in_data = data;
        @(negedge clk);
        if (in_ready && (be != 4'h0)) begin
            case (kind)
                KFwd: begin
                    e.onehot = 8'd1 << data[31:29];
                    e.data   = data;
                    sb_q.push_back(e);
                end
                KPart:   exp_part = sat(exp_part);
                KAddr:   exp_addr = sat(exp_addr);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_be = 4'h0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (tx_valid != 8'h00)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: tx_valid=%h tx_data=%h, expected no output",
                         tx_valid, tx_data);
            end else begin
                e = sb_q.pop_front();
                check("tx_valid_port", 32'(tx_valid), 32'(e.onehot));
                check("tx_data", tx_data, e.data);
            end
        end
    end

    vec_t vecs[8];
    logic [7:0] lat_exp[5];

    initial begin
        bit seen;

        // Reset state.
        #3;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_blocked", 32'(blocked), 0);
        check("rst_drop_addr", 32'(drop_addr_cnt), 0);
        check("rst_drop_partial", 32'(drop_partial_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Latency and back-to-back dispatch: outputs in cycles N+2..N+4.
        lat_exp = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04};
        fork
            begin
                send(4'hF, mk(3'd0, 32'h111), KFwd);
                send(4'hF, mk(3'd1, 32'h222), KFwd);
                send(4'hF, mk(3'd2, 32'h333), KFwd);
                in_be = 4'h0;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("latency_tx_valid", 32'(tx_valid), 32'(lat_exp[k]));
                    if (k < 3) check("latency_in_ready", 32'(in_ready), 1);
                end
            end
        join
        idle(3);

        // Backpressure: third word refused, head blocked until target drains.
        tx_full = 8'h08;
        send(4'hF, mk(3'd3, 32'hA1), KFwd);
        send(4'hF, mk(3'd3, 32'hA2), KFwd);
        in_be   = 4'hF;
        in_data = mk(3'd3, 32'hA3);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_blocked", 32'(blocked), 1);
        check("full_no_tx", 32'(tx_valid), 0);
        @(posedge clk);
        #1;
        idle(2);
        tx_full = 8'h00;
        idle(4);
        @(negedge clk);
        check("drain_in_ready", 32'(in_ready), 1);
        check("drain_blocked", 32'(blocked), 0);
        check("drain_sb_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;

        // Filtering vectors.
        vecs[0] = '{be: 4'h3, data: mk(3'd0, 1), en: 8'h0F, kind: KPart};
        vecs[1] = '{be: 4'h0, data: mk(3'd0, 2), en: 8'h0F, kind: KNone};
        vecs[2] = '{be: 4'hF, data: mk(3'd7, 3), en: 8'h0F, kind: KAddr};
        vecs[3] = '{be: 4'hF, data: mk(3'd2, 4), en: 8'h0F, kind: KFwd};
        vecs[4] = '{be: 4'h8, data: mk(3'd1, 5), en: 8'h0F, kind: KPart};
        vecs[5] = '{be: 4'hF, data: mk(3'd4, 6), en: 8'hFF, kind: KFwd};
        vecs[6] = '{be: 4'hF, data: mk(3'd6, 7), en: 8'h0F, kind: KAddr};
        vecs[7] = '{be: 4'hF, data: mk(3'd5, 8), en: 8'hDF, kind: KAddr};
        for (int i = 0; i < 8; i++) begin
            periph_en = vecs[i].en;
            send(vecs[i].be, vecs[i].data, vecs[i].kind);
            in_be = 4'h0;
            @(negedge clk);
            check("vec_drop_partial", 32'(drop_partial_cnt), 32'(exp_part));
            check("vec_drop_addr", 32'(drop_addr_cnt), 32'(exp_addr));
            @(posedge clk);
            #1;
        end
        check("vec_final_partial", 32'(exp_part), 2);
        idle(4);
        periph_en = 8'hFF;

        // Enable is sampled only at accept.
        tx_full = 8'h02;
        send(4'hF, mk(3'd1, 32'hE1), KFwd);
        in_be = 4'h0;
        periph_en = 8'h00;
        idle(2);
        tx_full = 8'h00;
        idle(4);
        check("late_disable_sb_empty", sb_q.size(), 0);
        periph_en = 8'h0F;

        // Saturation of the address-drop counter.
        @(negedge clk);
        force dut.drop_addr_q = 16'hFFFE;
        @(negedge clk);
        release dut.drop_addr_q;
        check("sat_preload", 32'(drop_addr_cnt), 32'h0000FFFE);
        exp_addr = 16'hFFFE;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send(4'hF, mk(3'd7, i), KAddr);
            in_be = 4'h0;
            @(negedge clk);
            check("sat_drop_addr", 32'(drop_addr_cnt), 32'h0000FFFF);
            @(posedge clk);
            #1;
        end
        periph_en = 8'hFF;

        // Reset mid-operation discards buffered packets.
        tx_full = 8'h08;
        send(4'hF, mk(3'd3, 32'hB1), KFwd);
        send(4'hF, mk(3'd3, 32'hB2), KFwd);
        in_be = 4'h0;
        @(negedge clk);
        check("pre_rst_blocked", 32'(blocked), 1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 0);
        check("mid_rst_count", 32'(dut.count_q), 0);
        check("mid_rst_drop_addr", 32'(drop_addr_cnt), 0);
        check("mid_rst_drop_partial", 32'(drop_partial_cnt), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_blocked", 32'(blocked), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_part = '0;
        exp_addr = '0;
        tx_full  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(tx_valid), 0);
        end
        @(posedge clk);
        #1;

        // Sustained stream, alternating ports, no bubbles.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(4'hF, mk(3'(i % 2), 32'h100 + i), KFwd);
                end
                in_be = 4'h0;
            end
            begin
                seen = 1'b0;
                for (int w = 0; w < 10 && !seen; w++) begin
                    @(negedge clk);
                    if (tx_valid != 8'h00) seen = 1'b1;
                end
                check("stream_start", 32'(seen), 1);
                for (int i = 1; i < 16; i++) begin
                    @(negedge clk);
                    check("stream_no_bubble", 32'(tx_valid != 8'h00), 1);
                end
            end
        join
        idle(4);
        check("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
